// File: rtl/camara_capture.sv
`default_nettype none
// ============================================================================
// Module   : camara_capture
// Purpose  : Capture front-end for an 8-bit parallel camera (OV7670 class).
//            Generates xclk and the reset/power-down sequence, synchronises
//            pclk/href/vsync/data into clk, assembles bytes into pixels
//            (RGB565 high byte first, or 8-bit grey) and writes them with
//            linear addresses to a frame buffer, with optional 2x2 decimation.
// Ports    : clk, rst_n (async, active low), enable, decim
//            vsync, href, pclk, data[7:0]          - sensor pins
//            xclk, cam_reset (low), cam_pwdn (high) - sensor control
//            pix_data[15:0], pix_addr, pix_we      - frame-buffer write port
//            frame_done, line_err                  - one-cycle status pulses
// Revision : 1.0 - initial release
// ============================================================================
module camara_capture #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BYTES_PIX = 2,
    parameter int ADDR_W    = 19,
    parameter int XCLK_DIV  = 2,
    parameter int RST_CYC   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              decim,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk,
    input  logic [7:0]        data,
    output logic              xclk,
    output logic              cam_reset,
    output logic              cam_pwdn,
    output logic [15:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_we,
    output logic              frame_done,
    output logic              line_err
);

    // Counter widths leave headroom above the active size so that over-long
    // lines / frames saturate instead of wrapping back into the window.
    localparam int c_col_w  = $clog2(H_ACTIVE + 1) + 1;
    localparam int c_row_w  = $clog2(V_ACTIVE + 1) + 1;
    localparam int c_pwr_w  = (RST_CYC  > 1) ? $clog2(RST_CYC)  : 1;
    localparam int c_xclk_w = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

    localparam logic [c_col_w-1:0]  c_h_active  = c_col_w'(H_ACTIVE);
    localparam logic [c_row_w-1:0]  c_v_active  = c_row_w'(V_ACTIVE);
    localparam logic [c_pwr_w-1:0]  c_pwr_last  = c_pwr_w'(RST_CYC - 1);
    localparam logic [c_xclk_w-1:0] c_xclk_last = c_xclk_w'(XCLK_DIV - 1);
    localparam logic                c_grey      = (BYTES_PIX == 1);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_PWRUP   = 2'd1,
        S_WAIT_VS = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_pwr_w-1:0]   r_pwr_cnt;
    logic [c_xclk_w-1:0]  r_xclk_cnt;
    // [0] metastability stage, [1] synchronised copy, [2] previous copy
    logic [2:0]           r_pclk_s;
    logic [2:0]           r_href_s;
    logic [2:0]           r_vsync_s;
    logic [7:0]           r_data_meta;
    logic [7:0]           r_data_sync;
    logic [7:0]           r_hi;
    logic                 r_phase;
    logic                 r_decim;
    logic [c_col_w-1:0]   r_col;
    logic [c_row_w-1:0]   r_row;
    logic [ADDR_W-1:0]    r_addr;

    logic                 w_pe;
    logic                 w_href_fall;
    logic                 w_vs_fall;
    logic                 w_vs_rise;
    logic                 w_take;
    logic                 w_pix_done;
    logic                 w_keep;
    logic [15:0]          w_pixel;

    // ------------------------------------------------------------------
    // Input synchronisers; data gets the same two-stage delay as pclk so
    // the byte seen at the detected pclk edge is the one the sensor held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pclk_s    <= '0;
            r_href_s    <= '0;
            r_vsync_s   <= '0;
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_pclk_s    <= {r_pclk_s[1:0],  pclk};
            r_href_s    <= {r_href_s[1:0],  href};
            r_vsync_s   <= {r_vsync_s[1:0], vsync};
            r_data_meta <= data;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_pe        =  r_pclk_s[1]  & ~r_pclk_s[2];
    assign w_href_fall = ~r_href_s[1]  &  r_href_s[2];
    assign w_vs_fall   = ~r_vsync_s[1] &  r_vsync_s[2];
    assign w_vs_rise   =  r_vsync_s[1] & ~r_vsync_s[2];

    // A byte can never be taken in the same cycle as a line end: taking
    // needs the synchronised href high, the line end needs it low.
    assign w_take     = (r_state == S_CAPTURE) & w_pe & r_href_s[1];
    assign w_pix_done = w_take & (c_grey | r_phase);
    assign w_pixel    = c_grey ? {8'h00, r_data_sync} : {r_hi, r_data_sync};
    assign w_keep     = (r_col < c_h_active) && (r_row < c_v_active) &&
                        (!r_decim || (!r_col[0] && !r_row[0]));

    // ------------------------------------------------------------------
    // Free-running camera master clock
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xclk_cnt <= '0;
            xclk       <= 1'b0;
        end else if (r_xclk_cnt == c_xclk_last) begin
            r_xclk_cnt <= '0;
            xclk       <= ~xclk;
        end else begin
            r_xclk_cnt <= r_xclk_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Power sequencer, frame tracking and pixel assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_OFF;
            r_pwr_cnt  <= '0;
            r_hi       <= '0;
            r_phase    <= 1'b0;
            r_decim    <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            cam_reset  <= 1'b0;
            cam_pwdn   <= 1'b1;
            pix_data   <= '0;
            pix_addr   <= '0;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            case (r_state)
                S_OFF: begin
                    cam_pwdn  <= 1'b1;
                    cam_reset <= 1'b0;
                    r_pwr_cnt <= '0;
                    if (enable) begin
                        r_state  <= S_PWRUP;
                        cam_pwdn <= 1'b0;
                    end
                end
                S_PWRUP: begin
                    if (!enable) begin
                        r_state  <= S_OFF;
                        cam_pwdn <= 1'b1;
                    end else if (r_pwr_cnt == c_pwr_last) begin
                        r_state   <= S_WAIT_VS;
                        cam_reset <= 1'b1;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end
                S_WAIT_VS: begin
                    if (!enable) begin
                        r_state   <= S_OFF;
                        cam_pwdn  <= 1'b1;
                        cam_reset <= 1'b0;
                    end else if (w_vs_fall) begin
                        r_state <= S_CAPTURE;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_phase <= 1'b0;
                        r_addr  <= '0;
                        r_decim <= decim;
                    end
                end
                S_CAPTURE: begin
                    if (w_take) begin
                        if (w_pix_done) begin
                            r_phase <= 1'b0;
                            if (r_col != '1) r_col <= r_col + 1'b1;
                            if (w_keep) begin
                                pix_we   <= 1'b1;
                                pix_data <= w_pixel;
                                pix_addr <= r_addr;
                                r_addr   <= r_addr + 1'b1;
                            end
                        end else begin
                            r_hi    <= r_data_sync;
                            r_phase <= 1'b1;
                        end
                    end
                    // Line end is handled before frame end so that a
                    // coincident vsync rise still closes the last line.
                    if (w_href_fall) begin
                        line_err <= (r_col != c_h_active) || r_phase;
                        if (r_row != '1) r_row <= r_row + 1'b1;
                        r_col   <= '0;
                        r_phase <= 1'b0;
                    end
                    if (w_vs_rise) begin
                        frame_done <= 1'b1;
                        if (enable) begin
                            r_state <= S_WAIT_VS;
                        end else begin
                            r_state   <= S_OFF;
                            cam_pwdn  <= 1'b1;
                            cam_reset <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

endmodule
`default_nettype wire
